memory_stage: RTL and testbench

Memory stage of the five-stage Y86-64 pipeline. Directly downstream of the execute stage. Holds the E→M pipeline register (M register) with stall/bubble control and a byte-addressed data memory. Performs the data-memory read/write for the instruction in M and supplies m_valM and m_stat to the write-back register and the forwarding logic.

---
 rtl/memory_stage.sv | 189 ++++++++++++++++++
 tb/tb_memory_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of the five-stage Y86-64 pipeline. This file holds the M
// pipeline register, with its stall and bubble controls, and a byte-addressed
// little-endian data memory. It produces the load data and the stage status.
module memory_stage #(
    parameter int         DMEM_BYTES = 1024,
    parameter logic [2:0] SAOK       = 3'd1,
    parameter logic [2:0] SHLT       = 3'd2,
    parameter logic [2:0] SADR       = 3'd3,
    parameter logic [2:0] SINS       = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic [2:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    output logic [2:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic        dmem_error
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam int          AW         = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;
    // Highest address at which a whole 8-byte word still fits in the memory.
    localparam logic [63:0] LAST_LEGAL = 64'(DMEM_BYTES - 8);
    localparam logic [3:0]  REG_NONE   = 4'hF;

    // The status codes must be distinct, or a fault could not be told apart
    // from an ordinary status. This empty block only names that dependency.
    if (SHLT == SAOK || SINS == SAOK || SADR == SAOK) begin : g_status_codes_collide
    end

    logic [2:0]  stat_q,  stat_d;
    logic [3:0]  icode_q, icode_d;
    logic        cnd_q,   cnd_d;
    logic [63:0] valE_q,  valE_d;
    logic [63:0] valA_q,  valA_d;
    logic [3:0]  dstE_q,  dstE_d;
    logic [3:0]  dstM_q,  dstM_d;

    logic [7:0]  mem_q [DMEM_BYTES];

    logic          rd_en;
    logic          wr_en;
    logic [63:0]   addr;
    logic [AW-1:0] base;
    logic          fault;
    logic          store_en;
    logic [63:0]   rdata;

    // M-register next state: a bubble overrides a stall, and a stall holds.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        valE_d  = valE_q;
        valA_d  = valA_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        if (M_bubble) begin
            stat_d  = SAOK;
            icode_d = I_NOP;
            cnd_d   = 1'b0;
            valE_d  = '0;
            valA_d  = '0;
            dstE_d  = REG_NONE;
            dstM_d  = REG_NONE;
        end else if (!M_stall) begin
            stat_d  = E_stat;
            icode_d = E_icode;
            cnd_d   = e_Cnd;
            valE_d  = e_valE;
            valA_d  = E_valA;
            // A cmov whose condition failed writes no register.
            dstE_d  = (E_icode == I_CMOVXX && !e_Cnd) ? REG_NONE : e_dstE;
            dstM_d  = E_dstM;
        end
    end

    // M-register state update; reset loads the bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q  <= SAOK;
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            valE_q  <= '0;
            valA_q  <= '0;
            dstE_q  <= REG_NONE;
            dstM_q  <= REG_NONE;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            valE_q  <= valE_d;
            valA_q  <= valA_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
        end
    end

    // Decode the access type and the effective address of the instruction in M.
    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        case (icode_q)
            I_MRMOVQ: begin
                rd_en = 1'b1;
                addr  = valE_q;
            end
            I_RET, I_POPQ: begin
                rd_en = 1'b1;
                addr  = valA_q;
            end
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                wr_en = 1'b1;
                addr  = valE_q;
            end
            default: begin
                rd_en = 1'b0;
                wr_en = 1'b0;
                addr  = '0;
            end
        endcase
    end

    // The full 64-bit compare keeps addresses near 2^64 from wrapping into range.
    assign fault    = (rd_en || wr_en) && (addr > LAST_LEGAL);
    assign base     = addr[AW-1:0];
    assign store_en = wr_en && (stat_q == SAOK) && !fault && !reset;

    // Combinational little-endian 8-byte load; reads 0 when disabled or faulting.
    always_comb begin
        rdata = '0;
        if (rd_en && !fault) begin
            for (int unsigned i = 0; i < 8; i++) begin
                rdata[8*i +: 8] = mem_q[base + AW'(i)];
            end
        end
    end

    // Store M_valA at the end of the cycle in which the store sits in M.
    // This array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem_q[base + AW'(i)] <= valA_q[8*i +: 8];
            end
        end
    end

    assign M_stat     = stat_q;
    assign M_icode    = icode_q;
    assign M_Cnd      = cnd_q;
    assign M_valE     = valE_q;
    assign M_valA     = valA_q;
    assign M_dstE     = dstE_q;
    assign M_dstM     = dstM_q;
    assign m_valM     = rdata;
    assign dmem_error = fault;
    assign m_stat     = fault ? SADR : stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard testbench for memory_stage. The driver issues one instruction
// each cycle and queues the expected state after the following clock edge.
// The monitor pops each entry and compares it with the DUT outputs.
module tb_memory_stage;

    localparam int         DMEM = 1024;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;

    logic        clk;
    logic        reset;
    logic        M_stall;
    logic        M_bubble;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic        e_Cnd;
    logic [63:0] e_valE;
    logic [63:0] E_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  E_dstM;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic        dmem_error;

    memory_stage #(.DMEM_BYTES(DMEM)) dut (
        .clk        (clk),
        .reset      (reset),
        .M_stall    (M_stall),
        .M_bubble   (M_bubble),
        .E_stat     (E_stat),
        .E_icode    (E_icode),
        .e_Cnd      (e_Cnd),
        .e_valE     (e_valE),
        .E_valA     (E_valA),
        .e_dstE     (e_dstE),
        .E_dstM     (E_dstM),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM),
        .m_valM     (m_valM),
        .m_stat     (m_stat),
        .dmem_error (dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } mreg_t;

    typedef struct {
        int          id;
        mreg_t       r;
        logic [63:0] valM;
        logic [2:0]  mstat;
        logic        derr;
    } exp_t;

    exp_t       sb_q[$];
    mreg_t      ref_m;
    logic [7:0] ref_mem [DMEM];
    int         checks = 0;
    int         errors = 0;
    int         step_id = 0;

    function automatic mreg_t bubble_val();
        mreg_t b;
        b.stat  = SAOK;
        b.icode = 4'h1;
        b.cnd   = 1'b0;
        b.valE  = '0;
        b.valA  = '0;
        b.dstE  = 4'hF;
        b.dstM  = 4'hF;
        return b;
    endfunction

    // Which kind of access an instruction makes, where, and whether the word fits.
    function automatic void classify(input mreg_t r, output bit rd, output bit wr,
                                     output logic [63:0] a, output bit bad);
        rd  = r.icode inside {4'h5, 4'h9, 4'hB};
        wr  = r.icode inside {4'h4, 4'h8, 4'hA};
        a   = (r.icode inside {4'h9, 4'hB}) ? r.valA : r.valE;
        bad = (rd || wr) && !(({1'b0, a} + 65'd7) < 65'(DMEM));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv,
                         input int id);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, id, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic step(input bit rst, input bit stl, input bit bub,
                        input logic [2:0] st, input logic [3:0] ic, input logic c,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm);
        bit          rd, wr, bad;
        logic [63:0] a;
        exp_t        e;
        @(negedge clk);
        reset = rst; M_stall = stl; M_bubble = bub;
        E_stat = st; E_icode = ic; e_Cnd = c; e_valE = ve; E_valA = va;
        e_dstE = de; E_dstM = dm;

        classify(ref_m, rd, wr, a, bad);
        if (wr && !bad && !rst && ref_m.stat == SAOK)
            for (int b = 0; b < 8; b++) ref_mem[int'(a) + b] = ref_m.valA[8*b +: 8];

        if (rst || bub) ref_m = bubble_val();
        else if (!stl) begin
            ref_m.stat  = st;
            ref_m.icode = ic;
            ref_m.cnd   = c;
            ref_m.valE  = ve;
            ref_m.valA  = va;
            ref_m.dstE  = (ic == 4'h2 && c == 1'b0) ? 4'hF : de;
            ref_m.dstM  = dm;
        end

        classify(ref_m, rd, wr, a, bad);
        e.id    = step_id;
        e.r     = ref_m;
        e.derr  = bad;
        e.mstat = bad ? SADR : ref_m.stat;
        e.valM  = '0;
        if (rd && !bad)
            for (int b = 0; b < 8; b++) e.valM[8*b +: 8] = ref_mem[int'(a) + b];
        sb_q.push_back(e);
        step_id++;
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 64'($urandom_range(0, 63));
            5, 6:          return 64'($urandom_range(0, DMEM - 1));
            7:             return 64'(DMEM - 8) + 64'($urandom_range(0, 8));
            8:             return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            default:       return {$urandom, $urandom};
        endcase
    endfunction

    task automatic rand_step(input bit force_stall);
        bit         rst, stl, bub;
        logic [2:0] st;
        rst = force_stall ? 1'b0 : ($urandom_range(0, 49) == 0);
        stl = force_stall ? 1'b1 : ($urandom_range(0, 9) == 0);
        bub = force_stall ? 1'b0 : ($urandom_range(0, 14) == 0);
        st  = ($urandom_range(0, 7) < 6) ? SAOK : 3'($urandom_range(1, 4));
        step(rst, stl, bub, st, 4'($urandom_range(0, 11)), 1'($urandom),
             rand_addr(), ($urandom_range(0, 1) == 1) ? rand_addr() : {$urandom, $urandom},
             4'($urandom), 4'($urandom));
    endtask

    // Monitor: compare every queued expectation just after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("M_stat",     64'(M_stat),     64'(e.r.stat),  e.id);
                check("M_icode",    64'(M_icode),    64'(e.r.icode), e.id);
                check("M_Cnd",      64'(M_Cnd),      64'(e.r.cnd),   e.id);
                check("M_valE",     M_valE,          e.r.valE,       e.id);
                check("M_valA",     M_valA,          e.r.valA,       e.id);
                check("M_dstE",     64'(M_dstE),     64'(e.r.dstE),  e.id);
                check("M_dstM",     64'(M_dstM),     64'(e.r.dstM),  e.id);
                check("m_valM",     m_valM,          e.valM,         e.id);
                check("m_stat",     64'(m_stat),     64'(e.mstat),   e.id);
                check("dmem_error", 64'(dmem_error), 64'(e.derr),    e.id);
            end
        end
    end

    initial begin
        reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
        E_stat = SAOK; E_icode = 4'h1; e_Cnd = 1'b0; e_valE = '0; E_valA = '0;
        e_dstE = 4'hF; E_dstM = 4'hF;
        ref_m = bubble_val();
        for (int i = 0; i < DMEM; i++) ref_mem[i] = 8'h00;

        // Reset with arbitrary inputs
        step(1, 0, 0, SHLT, 4'h5, 1, 64'h1234, 64'h5678, 4'h3, 4'h4);
        step(1, 1, 0, SAOK, 4'hA, 0, 64'h10, 64'h20, 4'h1, 4'h2);

        // Zero the whole memory through ordinary stores
        for (int a = 0; a < DMEM; a += 8)
            step(0, 0, 0, SAOK, 4'h4, 0, 64'(a), 64'h0, 4'hF, 4'hF);

        // Store/load round trip, plus loads straddling the stored word
        step(0, 0, 0, SAOK, 4'h4, 0, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h10, 64'h0, 4'hF, 4'h2);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h17, 64'h0, 4'hF, 4'h2);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h0F, 64'h0, 4'hF, 4'h2);

        // Cmov squash and pass-through
        step(0, 0, 0, SAOK, 4'h2, 0, 64'h7, 64'h7, 4'h3, 4'hF);
        step(0, 0, 0, SAOK, 4'h2, 1, 64'h7, 64'h7, 4'h3, 4'hF);

        // Address fault boundary and a wrapping store address
        step(0, 0, 0, SAOK, 4'h5, 0, 64'(DMEM - 7), 64'h0, 4'hF, 4'h1);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'(DMEM - 8), 64'h0, 4'hF, 4'h1);
        step(0, 0, 0, SAOK, 4'h4, 0, 64'hFFFF_FFFF_FFFF_FFFC, '1, 4'hF, 4'hF);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'(DMEM - 8), 64'h0, 4'hF, 4'h1);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h0, 64'h0, 4'hF, 4'h1);

        // A store whose status is not AOK writes nothing
        step(0, 0, 0, SHLT, 4'h4, 0, 64'h30, 64'hDEAD, 4'hF, 4'hF);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h30, 64'h0, 4'hF, 4'h1);

        // Stall holds a pushq; then stall plus bubble loads a bubble
        step(0, 0, 0, SAOK, 4'hA, 0, 64'h100, 64'h5, 4'h4, 4'hF);
        for (int i = 0; i < 3; i++) rand_step(1'b1);
        step(0, 1, 1, SAOK, 4'h5, 1, 64'h200, 64'h9, 4'h2, 4'h3);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h100, 64'h0, 4'hF, 4'h1);

        // Reset on the edge that ends a store suppresses it
        step(0, 0, 0, SAOK, 4'h4, 0, 64'h40, 64'h55, 4'hF, 4'hF);
        step(1, 0, 0, SAOK, 4'h6, 0, 64'h0, 64'h0, 4'h1, 4'hF);
        step(0, 0, 0, SAOK, 4'h5, 0, 64'h40, 64'h0, 4'hF, 4'h1);

        // popq, ret and call addressing
        step(0, 0, 0, SAOK, 4'h4, 0, 64'h200, 64'hABCD, 4'hF, 4'hF);
        step(0, 0, 0, SAOK, 4'hB, 0, 64'h208, 64'h200, 4'h4, 4'h5);
        step(0, 0, 0, SAOK, 4'h9, 0, 64'h208, 64'h200, 4'h4, 4'hF);
        step(0, 0, 0, SAOK, 4'h8, 0, 64'h80, 64'h1234, 4'h4, 4'hF);
        step(0, 0, 0, SAOK, 4'h9, 0, 64'h88, 64'h80, 4'h4, 4'hF);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) rand_step(1'b0);

        repeat (2) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
